// File: rtl/square_stage_pipe.sv
// square_stage_pipe: per-channel square with valid/ready pipeline; define SQ_SAT_EN to saturate squares above 2^W-1
module square_stage_pipe #(
  parameter int N_CH = 9,
  parameter int W = 8,
  parameter int LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_CH*W-1:0]   p_in,
  input  logic [N_CH*W-1:0]   c_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_CH*W-1:0]   p_out,
  output logic [N_CH*W-1:0]   c_out,
  output logic [15:0]         beat_cnt
);
  logic [LAT-1:0]      v;
  logic [N_CH*W-1:0]   p [LAT];
  logic [N_CH*W-1:0]   c [LAT];
  logic [N_CH*W-1:0]   sq_red;
  logic                stall;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v[LAT-1];
  assign p_out     = p[LAT-1];
  assign c_out     = c[LAT-1];
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [2*W-1:0] sq;
    assign sq = c_in[k*W +: W] * c_in[k*W +: W];
`ifdef SQ_SAT_EN
    assign sq_red[k*W +: W] = (|sq[2*W-1:W]) ? {W{1'b1}} : sq[W-1:0];
`else
    assign sq_red[k*W +: W] = sq[W-1:0];
`endif
  end
  // whole pipe shifts together unless the output is stalled; stage 0 captures the squared beat
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) begin
        p[i] <= '0;
        c[i] <= '0;
      end
    end else if (!stall) begin
      v[0] <= in_valid;
      p[0] <= p_in;
      c[0] <= sq_red;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        p[i] <= p[i-1];
        c[i] <= c[i-1];
      end
    end
  end
  // count delivered beats, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (rst) beat_cnt <= '0;
    else if (out_valid && out_ready) beat_cnt <= beat_cnt + 16'd1;
  end
endmodule

// File: doc/square_stage_pipe.md
SQUARE_STAGE_PIPE -- requirements
Module: square_stage_pipe

Interface
REQ-001 The block SHALL have parameter N_CH, default 9, meaning the number of parallel channels.
REQ-002 The block SHALL have parameter W, default 8, meaning the bit width per channel element.
REQ-003 The block SHALL have parameter LAT, default 2, legal range 1..8, meaning the number of pipeline stages from input acceptance to output.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input beat is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have port p_in, input, N_CH*W bits: pass-through elements; channel k occupies bits [k*W +: W].
REQ-009 The block SHALL have port c_in, input, N_CH*W bits: elements to square, packed as for p_in.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the output beat is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the beat.
REQ-012 The block SHALL have port p_out, output, N_CH*W bits: the delayed p_in, aligned with c_out.
REQ-013 The block SHALL have port c_out, output, N_CH*W bits: per-channel square of c_in, reduced to W bits.
REQ-014 The block SHALL have port beat_cnt, output, 16 bits: the count of beats delivered downstream.

Function
REQ-015 A beat SHALL be accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
REQ-016 The pipeline SHALL hold LAT stages, each with one valid bit, its p data and its c data.
REQ-017 Stall SHALL be defined as out_valid && !out_ready; on stall, every stage SHALL hold its contents.
REQ-018 in_ready SHALL equal !stall, driven combinationally with no register in the path.
REQ-019 When not stalled, each stage SHALL advance by one position; stage 0 SHALL load the accepted beat with valid = in_valid.
REQ-020 Empty (bubble) stages SHALL advance even when stalled only if a downstream stage is also empty; this compression is optional. Without compression, the global-stall behaviour of REQ-017 SHALL apply.
REQ-021 out_valid, p_out and c_out SHALL be driven from the last stage, giving a latency of exactly LAT cycles from acceptance to out_valid with no stall.
REQ-022 Throughput SHALL be one beat per cycle while out_ready is held high.
REQ-023 Each channel SHALL compute its square c*c at the full 2W bits, unsigned.
REQ-024 The squaring logic SHALL be placed in stage 0, with the remaining stages acting as a delay; results SHALL be identical for any LAT.
REQ-025 The reduction of the 2W-bit square to W bits SHALL be as defined in the Configuration section.
REQ-026 Each p element SHALL pass unmodified, staying aligned with the c element of the same beat.
REQ-027 beat_cnt SHALL increment by 1 on every delivered beat and wrap from 16'hFFFF to 0.
REQ-028 Data on out_valid SHALL remain stable while stalled.
REQ-029 If in_valid is high during a stall, the beat SHALL NOT be accepted, and upstream SHALL hold it.

Reset
REQ-030 While rst is high at a rising clk edge, all stage valid bits, out_valid and beat_cnt SHALL clear to 0.
REQ-031 During reset, p_out and c_out SHALL read 0, with the stage data registers also cleared.
REQ-032 Reset mid-operation SHALL discard all in-flight beats with no partial output.
REQ-033 The first acceptance after reset SHALL be possible in the cycle after rst falls, because in_ready = 1 when the pipe is empty.

Configuration
REQ-034 The macro SQ_SAT_EN SHALL control saturation: defined, each channel outputs the square if it is at most 2^W-1, else all-ones (2^W-1).
REQ-035 With SQ_SAT_EN undefined, each channel SHALL output the low W bits of the square (modulo 2^W).
REQ-036 No other behaviour, latency or interface SHALL change with SQ_SAT_EN.

Verification (N_CH=9, W=8, LAT=2)
REQ-037 Reset with inputs toggling SHALL give out_valid=0, p_out=0, c_out=0 and beat_cnt=0 throughout reset.
REQ-038 A single beat c_in channels = 15, p_in = 8'hA5, out_ready=1 SHALL give out_valid exactly 2 cycles later with c_out channels = 225 and p_out = 8'hA5.
REQ-039 A beat with c=20 SHALL give 255 with SQ_SAT_EN defined and 144 without; a beat with c=16 SHALL give 255 and 0 respectively.
REQ-040 Ten back-to-back beats with distinct c values and out_ready=1 SHALL give ten consecutive out_valid cycles, in order, with beat_cnt=10.
REQ-041 Holding out_ready=0 for 5 cycles with the pipe full SHALL drop in_ready to 0 and keep output data stable; releasing it SHALL resume in order with no loss or duplication.
REQ-042 Asserting rst with 2 beats in flight SHALL make no out_valid appear afterwards until new input arrives, and beat_cnt SHALL be 0.
